snes_rom_parser: RTL and testbench
==================================

# snes_rom_parser

Snoops the cartridge image as it streams into SDRAM and classifies the SNES memory map from the internal header. Sits beside the ROM download path on the memory clock and feeds `parsed_rom_type` to the cartridge mapper/config logic. Optional 512-byte copier headers are detected from the file size. Each candidate header location is scored, and the best-scoring map type is reported when the download ends.

## Interface
Parameters:
- `ADDR_W`, 25: download byte-address width.

Ports:
- `clk_mem`  in  1  memory/download clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rom_file_size`  in  32  total file size in bytes; stable for the whole download.
- `addr`  in  ADDR_W  byte address of the current word; always even.
- `data`  in  16  `data[7:0]` is byte `addr`, `data[15:8]` is byte `addr+1`.
- `downloading`  in  1  high while the image is streaming.
- `parsed_rom_type`  out  3  map type:
  - 0 LoROM
  - 1 HiROM
  - 2 ExHiROM
  - 3–7 reserved, never driven.

## Operation
- Copier offset: `OFS = 0x200` if `rom_file_size[9:0] == 0x200`, else 0.
- Candidate header bases, relative to the file start: LoROM `0x7FC0+OFS`, HiROM `0xFFC0+OFS`, ExHiROM `0x40FFC0+OFS`.
- Captured bytes per candidate, at base+offset:
  - map mode at `+0x15`
  - ROM size at `+0x17`
  - checksum complement at `+0x1C/+0x1D`
  - checksum at `+0x1E/+0x1F`
  - reset vector at `+0x3C/+0x3D`
- Capture rule: while `downloading` is high, every clock compares `addr` (and `addr+1`) against each captured byte address and loads matching bytes. Re-presenting the same word is idempotent.
- Score per candidate, range 0–5:
  - +2 if complement + checksum == 0xFFFF (16-bit compare)
  - +1 if the map-mode match holds:
    - LoROM: `mode[0]==0`
    - HiROM: `mode[0]==1`
    - ExHiROM: `mode[3:0]==5`
  - +1 if reset vector ≥ 0x8000
  - +1 if ROM size byte is within 0x08..0x0D
- Candidate eligibility: a candidate is eligible only if `rom_file_size ≥ base+0x40`. An ineligible candidate scores 0.
- Decision: the highest score wins. Ties resolve LoROM > HiROM > ExHiROM. If all scores are 0, the result is LoROM (0).
- Start of download (`downloading` rising edge): clears all captured bytes to 0. `parsed_rom_type` keeps its previous value until the new decision.
- Arithmetic: scores are 3-bit unsigned; sums are computed in 17 bits and compared against 0x0FFFF.

## Timing
- Reset: all captured bytes are 0, `parsed_rom_type = 0`, edge-detect register is 0.
- The capture register updates one clock after the address/data sample.
- Scores are registered continuously, one clock after capture.
- On the falling edge of `downloading` (detected the clock after it is sampled low), `parsed_rom_type` loads the decision. It is valid 2 clocks after `downloading` is first sampled low.
- If `downloading` re-asserts before the decision, the decision is aborted and capture restarts.
- Reset mid-download: all state clears immediately; no decision is made for the interrupted download.
- Addresses beyond `2^ADDR_W` are never matched.

## Configuration
- `SNES_ROM_PARSER_EXHIROM_EN`
  - Defined: the ExHiROM candidate is captured and scored.
  - Undefined: its capture logic is omitted, its score is tied to 0, and `parsed_rom_type` is never 2.

## Structure
- Package `snes_rom_parser_pkg`:
  - `rom_type_e` enum (LOROM=0, HIROM=1, EXHIROM=2)
  - header base constants
  - field offsets
  - `COPIER_HDR = 0x200`
- Sub-module `snes_header_scorer`:
  - one instance per candidate
  - parameter: base address
  - inputs: `addr`, `data`, capture enable, clear, `OFS`, `rom_file_size`
  - output: registered 3-bit score.

## Test plan
- HiROM image, size 0x100200: at 0x101DC/0x101DE put complement/checksum 0x1234/0xEDCB, mode 0x31, vector 0x8000, size 0x0A. LoROM header region all 0. → `parsed_rom_type = 1`.
- LoROM image, size 0x80000, no copier: at 0x7FD5 put mode 0x20, checksum pair summing to 0xFFFF, vector 0x8123. → 0.
- Scoring tie: both headers score 5 → 0 (LoROM precedence).
- ExHiROM image, size 0x600000: header at 0x40FFC0 with mode 0x35, valid checksum, vector 0x8000. → 2 with the macro defined; → 0 or 1 (per lower headers) without it.
- Size 0x4000 (too small for any header) → 0.
- Assert `reset` mid-download after HiROM header bytes were captured, then finish a blank download → 0.

Source files
------------

// File: rtl/snes_rom_parser_pkg.sv
// Shared types, header geometry and scoring helpers for the SNES internal-header parser.
package snes_rom_parser_pkg;

  typedef enum logic [2:0] {
    LOROM   = 3'd0,
    HIROM   = 3'd1,
    EXHIROM = 3'd2
  } rom_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DECIDE
  } state_e;

  localparam logic [31:0] LOROM_BASE   = 32'h0000_7FC0;
  localparam logic [31:0] HIROM_BASE   = 32'h0000_FFC0;
  localparam logic [31:0] EXHIROM_BASE = 32'h0040_FFC0;
  localparam logic [31:0] COPIER_HDR   = 32'h0000_0200;
  localparam logic [31:0] HDR_SPAN     = 32'h0000_0040;

  localparam logic [5:0] OFS_MAP     = 6'h15;
  localparam logic [5:0] OFS_ROMSIZE = 6'h17;
  localparam logic [5:0] OFS_CMPL    = 6'h1C;
  localparam logic [5:0] OFS_CSUM    = 6'h1E;
  localparam logic [5:0] OFS_VEC     = 6'h3C;

  localparam int unsigned NUM_FIELD_BYTES = 8;

  // Captured byte slots: map, romsize, cmpl lo/hi, csum lo/hi, vector lo/hi.
  function automatic logic [5:0] field_ofs(int unsigned idx);
    case (idx)
      0:       return OFS_MAP;
      1:       return OFS_ROMSIZE;
      2:       return OFS_CMPL;
      3:       return OFS_CMPL + 6'd1;
      4:       return OFS_CSUM;
      5:       return OFS_CSUM + 6'd1;
      6:       return OFS_VEC;
      7:       return OFS_VEC + 6'd1;
      default: return '0;
    endcase
  endfunction

  function automatic logic mode_ok(rom_type_e kind, logic [7:0] mode);
    case (kind)
      LOROM:   return ~mode[0];
      HIROM:   return mode[0];
      EXHIROM: return (mode[3:0] == 4'h5);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/snes_rom_parser_if.sv
// Download-side bus snooped by the ROM parser, plus the parsed map-type result.
interface snes_rom_parser_if #(
  parameter int unsigned ADDR_W = 25
);
  logic [31:0]       rom_file_size;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data;
  logic              downloading;
  logic [2:0]        parsed_rom_type;

  modport master (
    output rom_file_size, addr, data, downloading,
    input  parsed_rom_type
  );

  modport slave (
    input  rom_file_size, addr, data, downloading,
    output parsed_rom_type
  );
endinterface

// File: rtl/snes_header_scorer.sv
// Captures one candidate internal header from the download stream and scores it 0..5.
module snes_header_scorer
  import snes_rom_parser_pkg::*;
#(
  parameter int unsigned ADDR_W = 25,
  parameter logic [31:0] BASE   = LOROM_BASE,
  parameter rom_type_e   KIND   = LOROM
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       data_i,
  input  logic              cap_en_i,
  input  logic              clr_i,
  input  logic [31:0]       ofs_i,
  input  logic [31:0]       rom_file_size_i,
  output logic [2:0]        score_o
);

  logic [7:0]  fld_q [NUM_FIELD_BYTES];
  logic [7:0]  fld_d [NUM_FIELD_BYTES];
  logic [2:0]  score_q, score_d;
  logic [31:0] addr_w, hdr_base;
  logic [15:0] cmpl, csum, vec;
  logic [16:0] sum;
  logic        eligible;

  assign addr_w   = 32'(addr_i);
  assign hdr_base = BASE + ofs_i;

  // Word-address compare covers both the even byte and addr+1; clear and
  // capture in the same cycle keeps the first word of a new download.
  always_comb begin
    logic [31:0] tgt;
    tgt = '0;
    for (int unsigned i = 0; i < NUM_FIELD_BYTES; i++) begin
      tgt      = hdr_base + 32'(field_ofs(i));
      fld_d[i] = clr_i ? '0 : fld_q[i];
      if (cap_en_i && (addr_w[31:1] == tgt[31:1])) begin
        fld_d[i] = tgt[0] ? data_i[15:8] : data_i[7:0];
      end
    end
  end

  assign cmpl     = {fld_q[3], fld_q[2]};
  assign csum     = {fld_q[5], fld_q[4]};
  assign vec      = {fld_q[7], fld_q[6]};
  assign sum      = {1'b0, cmpl} + {1'b0, csum};
  assign eligible = (rom_file_size_i >= hdr_base + HDR_SPAN);

  always_comb begin
    score_d = '0;
    if (eligible) begin
      if (sum == 17'h0FFFF)                           score_d = score_d + 3'd2;
      if (mode_ok(KIND, fld_q[0]))                    score_d = score_d + 3'd1;
      if (vec >= 16'h8000)                            score_d = score_d + 3'd1;
      if ((fld_q[1] >= 8'h08) && (fld_q[1] <= 8'h0D)) score_d = score_d + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_FIELD_BYTES; i++) fld_q[i] <= '0;
      score_q <= '0;
    end else begin
      fld_q   <= fld_d;
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/snes_rom_parser.sv
// Classifies the SNES memory map from streamed header candidates at end of download.
// Build option: SNES_ROM_PARSER_EXHIROM_EN adds the ExHiROM candidate.
module snes_rom_parser
  import snes_rom_parser_pkg::*;
#(
  parameter int unsigned ADDR_W = 25
) (
  input logic             clk_mem,
  input logic             reset,
  snes_rom_parser_if.slave bus
);

  state_e    state_q, state_d;
  rom_type_e type_q, type_d;
  rom_type_e best;
  logic      clr;
  logic [31:0] ofs;
  logic [2:0]  score_lo, score_hi, score_ex;

  assign ofs = (bus.rom_file_size[9:0] == 10'h200) ? COPIER_HDR : '0;

  snes_header_scorer #(.ADDR_W(ADDR_W), .BASE(LOROM_BASE), .KIND(LOROM)) u_lo (
    .clk_i(clk_mem), .rst_i(reset), .addr_i(bus.addr), .data_i(bus.data),
    .cap_en_i(bus.downloading), .clr_i(clr), .ofs_i(ofs),
    .rom_file_size_i(bus.rom_file_size), .score_o(score_lo)
  );

  snes_header_scorer #(.ADDR_W(ADDR_W), .BASE(HIROM_BASE), .KIND(HIROM)) u_hi (
    .clk_i(clk_mem), .rst_i(reset), .addr_i(bus.addr), .data_i(bus.data),
    .cap_en_i(bus.downloading), .clr_i(clr), .ofs_i(ofs),
    .rom_file_size_i(bus.rom_file_size), .score_o(score_hi)
  );

`ifdef SNES_ROM_PARSER_EXHIROM_EN
  snes_header_scorer #(.ADDR_W(ADDR_W), .BASE(EXHIROM_BASE), .KIND(EXHIROM)) u_ex (
    .clk_i(clk_mem), .rst_i(reset), .addr_i(bus.addr), .data_i(bus.data),
    .cap_en_i(bus.downloading), .clr_i(clr), .ofs_i(ofs),
    .rom_file_size_i(bus.rom_file_size), .score_o(score_ex)
  );
`else
  assign score_ex = '0;
`endif

  // Strict greater-than keeps LoROM > HiROM > ExHiROM precedence on ties.
  always_comb begin
    best = LOROM;
    if ((score_hi > score_lo) && (score_hi >= score_ex)) best = HIROM;
    if ((score_ex > score_lo) && (score_ex > score_hi))  best = EXHIROM;
  end

  // DECIDE is the cycle after downloading is first seen low; scores are
  // settled by then, and a re-assert there aborts into a fresh capture.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.downloading) begin
          clr     = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!bus.downloading) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (bus.downloading) begin
          clr     = 1'b1;
          state_d = ST_CAPTURE;
        end else begin
          type_d  = best;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= LOROM;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
    end
  end

  assign bus.parsed_rom_type = type_q;

endmodule

// File: tb/tb_snes_rom_parser.sv
// Randomized and directed checks of snes_rom_parser against a byte-image reference model.
module tb_snes_rom_parser;

  localparam int unsigned AW = 25;
`ifdef SNES_ROM_PARSER_EXHIROM_EN
  localparam bit EX_EN = 1'b1;
`else
  localparam bit EX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snes_rom_parser_if #(.ADDR_W(AW)) bus ();

  snes_rom_parser #(.ADDR_W(AW)) dut (
    .clk_mem(clk),
    .reset  (reset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cur_size;
  int prev_exp = 0;
  byte unsigned mem[int];
  byte unsigned stage[int];

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int base_of(input int k);
    case (k)
      0:       return 32'h7FC0;
      1:       return 32'hFFC0;
      default: return 32'h40FFC0;
    endcase
  endfunction

  function automatic int rd(input int a);
    return mem.exists(a) ? int'(mem[a]) : 0;
  endfunction

  function automatic int ref_score(input int kind, input int size);
    int b, mode, rs, cm, cs, vec, s;
    b = base_of(kind) + (((size % 1024) == 512) ? 512 : 0);
    if (size < b + 64) return 0;
    mode = rd(b + 21);
    rs   = rd(b + 23);
    cm   = rd(b + 28) + 256 * rd(b + 29);
    cs   = rd(b + 30) + 256 * rd(b + 31);
    vec  = rd(b + 60) + 256 * rd(b + 61);
    s = 0;
    if (cm + cs == 65535) s += 2;
    if (kind == 0 && (mode % 2) == 0)  s++;
    if (kind == 1 && (mode % 2) == 1)  s++;
    if (kind == 2 && (mode % 16) == 5) s++;
    if (vec >= 32768) s++;
    if (rs >= 8 && rs <= 13) s++;
    return s;
  endfunction

  function automatic int ref_type(input int size);
    int s0, s1, s2, r, best;
    s0 = ref_score(0, size);
    s1 = ref_score(1, size);
    s2 = EX_EN ? ref_score(2, size) : 0;
    r = 0; best = s0;
    if (s1 > best) begin r = 1; best = s1; end
    if (s2 > best) r = 2;
    return r;
  endfunction

  task automatic put_word(input int a, input int d);
    @(negedge clk);
    bus.addr        = a[AW-1:0];
    bus.data        = d[15:0];
    bus.downloading = 1'b1;
    mem[a]     = d[7:0];
    mem[a + 1] = d[15:8];
  endtask

  task automatic begin_img(input int size);
    @(negedge clk);
    bus.rom_file_size = size;
    cur_size = size;
    mem.delete();
    stage.delete();
  endtask

  task automatic stage8(input int a, input int v);
    stage[a] = v[7:0];
  endtask

  task automatic stage16(input int a, input int v);
    stage[a]     = v[7:0];
    stage[a + 1] = v[15:8];
  endtask

  task automatic stage_full(input int b, input int mode, input int cm, input int cs,
                            input int vec, input int rsz);
    for (int i = 0; i < 64; i++) stage8(b + i, 0);
    stage8(b + 21, mode);
    stage8(b + 23, rsz);
    stage16(b + 28, cm);
    stage16(b + 30, cs);
    stage16(b + 60, vec);
  endtask

  task automatic stage_header(input int b, input int kind);
    int m, c;
    for (int i = 0; i < 64; i++) stage8(b + i, $urandom_range(0, 255));
    m = $urandom_range(0, 255);
    if ($urandom_range(0, 9) < 7) begin
      case (kind)
        0:       m = m & 'hFE;
        1:       m = m | 1;
        default: m = (m & 'hF0) | 5;
      endcase
    end
    stage8(b + 21, m);
    c = $urandom_range(0, 65535);
    stage16(b + 30, c);
    stage16(b + 28, ($urandom_range(0, 9) < 7) ? 65535 - c : $urandom_range(0, 65535));
    stage16(b + 60, ($urandom_range(0, 9) < 7) ? $urandom_range(32768, 65535)
                                               : $urandom_range(0, 32767));
    stage8(b + 23, ($urandom_range(0, 9) < 7) ? $urandom_range(8, 13) : $urandom_range(0, 255));
  endtask

  task automatic stream_stage();
    bit ws[int];
    int d;
    foreach (stage[k]) ws[k & ~1] = 1'b1;
    foreach (ws[w]) begin
      d = (stage.exists(w + 1) ? int'(stage[w + 1]) : 0) * 256
        + (stage.exists(w) ? int'(stage[w]) : 0);
      put_word(w, d);
      if ($urandom_range(0, 7) == 0) put_word(w, d);
    end
  endtask

  task automatic finish_img(input string tag, input int exp);
    @(negedge clk);
    bus.downloading = 1'b0;
    @(negedge clk);
    check_eq({tag, "_hold"}, int'(bus.parsed_rom_type), prev_exp);
    @(negedge clk);
    check_eq(tag, int'(bus.parsed_rom_type), exp);
    prev_exp = exp;
  endtask

  task automatic run_hirom();
    begin_img(32'h100200);
    stage_full(32'h101C0, 'h31, 'h1234, 'hEDCB, 'h8000, 'h0A);
    for (int i = 0; i < 64; i++) stage8(32'h81C0 + i, 0);
    stream_stage();
    finish_img("hirom", 1);
  endtask

  int sizes[15] = '{32'h4000, 32'h7FFF, 32'h8000, 32'h8200, 32'hFFFF, 32'h10000, 32'h10200,
                    32'h80000, 32'h100000, 32'h100200, 32'h40FFFF, 32'h410000, 32'h410200,
                    32'h600000, 32'h600200};

  initial begin
    int sz, ofs;
    reset = 1'b1;
    bus.rom_file_size = '0;
    bus.addr = '0;
    bus.data = '0;
    bus.downloading = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_type", int'(bus.parsed_rom_type), 0);
    reset = 1'b0;

    run_hirom();

    // Reset mid-download discards the interrupted image; a blank image follows.
    begin_img(32'h100200);
    stage_full(32'h101C0, 'h31, 'h1234, 'hEDCB, 'h8000, 'h0A);
    stream_stage();
    @(negedge clk);
    reset = 1'b1;
    bus.addr = '0;
    bus.data = '0;
    @(negedge clk);
    check_eq("mid_reset", int'(bus.parsed_rom_type), 0);
    reset = 1'b0;
    mem.delete();
    prev_exp = 0;
    put_word(0, 0);
    put_word(32'h100, 32'h1234);
    finish_img("rst_blank", 0);

    run_hirom();

    begin_img(32'h100000);
    stage_full(32'h7FC0, 'h20, 'h1111, 'hEEEE, 'h8000, 'h0A);
    stage_full(32'hFFC0, 'h21, 'h2222, 'hDDDD, 'h9000, 'h0C);
    stream_stage();
    finish_img("tie", 0);

    run_hirom();

    begin_img(32'h80000);
    stage_full(32'h7FC0, 'h20, 'h5A5A, 'hA5A5, 'h8123, 'h00);
    stream_stage();
    finish_img("lorom", 0);

    begin_img(32'h600000);
    stage_full(32'h40FFC0, 'h35, 'h0F0F, 'hF0F0, 'h8000, 'h0C);
    stream_stage();
    finish_img("exhirom", EX_EN ? 2 : 0);

    run_hirom();

    begin_img(32'h4000);
    stage_full(32'h7FC0, 'h20, 'h1111, 'hEEEE, 'h8000, 'h0A);
    stage_full(32'hFFC0, 'h21, 'h2222, 'hDDDD, 'h9000, 'h0C);
    stream_stage();
    finish_img("too_small", 0);

    for (int it = 0; it < 80; it++) begin
      sz = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 32'h700000)
                                       : sizes[$urandom_range(0, 14)];
      begin_img(sz);
      ofs = ((sz % 1024) == 512) ? 512 : 0;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) != 0) stage_header(base_of(k) + ofs, k);
        else if ($urandom_range(0, 1) == 1) stage_header(base_of(k) + 512 - ofs, k);
      end
      stream_stage();
      for (int n = 0; n < $urandom_range(1, 4); n++) begin
        if ($urandom_range(0, 1) == 1)
          put_word(base_of($urandom_range(0, 2)) + ofs + 2 * $urandom_range(0, 31),
                   $urandom_range(0, 65535));
        else
          put_word(2 * $urandom_range(0, 32'h210000), $urandom_range(0, 65535));
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        bus.downloading = 1'b0;
        @(negedge clk);
        bus.addr = '0;
        bus.data = '0;
        bus.downloading = 1'b1;
        mem.delete();
        mem[0] = 0;
        mem[1] = 0;
        @(negedge clk);
        check_eq("abort_hold", int'(bus.parsed_rom_type), prev_exp);
        stream_stage();
      end
      finish_img("rand", ref_type(cur_size));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
